// File: rtl/ode_pkg.sv
// Shared definitions for the Euler matrix-vector MAC stage: FSM encoding,
// default Q-format and the saturation limits of the row result.
package ode_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StFetch,
    StDrain,
    StWait,
    StDone
  } state_e;

  localparam int unsigned DATA_SIZE_DEFAULT = 16;
  localparam int unsigned FRAC_BITS_DEFAULT = 8;
  // Extra accumulator headroom above the full product width.
  localparam int unsigned ACC_GUARD = 8;

  // Largest value representable in a signed field of the given width.
  function automatic longint sat_max(int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a signed field of the given width.
  function automatic longint sat_min(int unsigned width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate with Q-format rescale and saturation of each row sum.
module mac_unit
  import ode_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEFAULT,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid,
  input  logic                        first,
  input  logic                        last,
  input  logic [7:0]                  row,
  input  logic signed [DATA_SIZE-1:0] data_mat,
  input  logic signed [DATA_SIZE-1:0] data_vec,
  output logic [DATA_SIZE-1:0]        row_result,
  output logic                        row_valid,
  output logic [7:0]                  row_index
);

  localparam int unsigned PROD_W = 2 * DATA_SIZE;
  localparam int unsigned ACC_W  = PROD_W + ACC_GUARD;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(DATA_SIZE));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(DATA_SIZE));

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  shifted;
  logic [DATA_SIZE-1:0]     sat_val;

  // Next accumulator value and the saturated row result it would produce.
  always_comb begin
    prod     = data_mat * data_vec;
    prod_ext = $signed({{ACC_GUARD{prod[PROD_W-1]}}, prod});
    acc_d    = acc_q;
    if (valid) begin
      // Column 0 starts a fresh row sum.
      acc_d = first ? prod_ext : acc_q + prod_ext;
    end
    shifted = acc_d >>> FRAC_BITS;
    if (shifted > SAT_HI) begin
      sat_val = SAT_HI[DATA_SIZE-1:0];
    end else if (shifted < SAT_LO) begin
      sat_val = SAT_LO[DATA_SIZE-1:0];
    end else begin
      sat_val = shifted[DATA_SIZE-1:0];
    end
  end

  // Accumulator plus the held row result, published on the last column of a row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q      <= '0;
      row_valid  <= 1'b0;
      row_result <= '0;
      row_index  <= '0;
    end else begin
      acc_q     <= acc_d;
      row_valid <= valid & last;
      if (valid && last) begin
        row_result <= sat_val;
        row_index  <= row;
      end
    end
  end

endmodule

// File: rtl/euler_mac_stage.sv
// Matrix-vector pass controller: sequences fetch PCs over an N x N matrix and
// feeds the returned elements to the MAC datapath one cycle later.
module euler_mac_stage
  import ode_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEFAULT,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           dim,
  input  logic [DATA_SIZE-1:0] data_mat,
  input  logic [DATA_SIZE-1:0] data_vec,
  output logic                 init_start,
  output logic                 enable,
  output logic                 finished_one_row,
  output logic                 final_done,
  output logic [DATA_SIZE-1:0] row_result,
  output logic                 row_valid,
  output logic [7:0]           row_index,
  output logic                 busy
);

  state_e     state_q, state_d;
  logic [7:0] dim_q, dim_last;
  logic [7:0] col_q, row_q;
  logic       last_col, last_row;

  // Enable-cycle attributes delayed to line up with the RAM read data.
  logic       mac_valid_q, mac_first_q, mac_last_q;
  logic [7:0] mac_row_q;

  assign dim_last = dim_q - 8'd1;
  assign last_col = (col_q == dim_last);
  assign last_row = (row_q == dim_last);
  assign busy     = (state_q != StIdle);

  // Next-state and fetch-control outputs.
  always_comb begin
    state_d          = state_q;
    init_start       = 1'b0;
    enable           = 1'b0;
    finished_one_row = 1'b0;
    final_done       = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && (dim != 8'd0)) state_d = StInit;
      end
      StInit: begin
        init_start = 1'b1;
        state_d    = StFetch;
      end
      StFetch: begin
        enable           = 1'b1;
        finished_one_row = last_col;
        if (last_col && last_row) state_d = StDrain;
      end
      StDrain: begin
        final_done = 1'b1;
        state_d    = StWait;
      end
      StWait: begin
        // Only the final row can complete while waiting here.
        if (row_valid && (row_index == dim_last)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, latched dimension, row/column counters and the read-latency pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      dim_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      mac_valid_q <= 1'b0;
      mac_first_q <= 1'b0;
      mac_last_q  <= 1'b0;
      mac_row_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && start && (dim != 8'd0)) dim_q <= dim;
      if (state_q == StInit) begin
        col_q <= '0;
        row_q <= '0;
      end else if (enable) begin
        if (last_col) begin
          col_q <= '0;
          row_q <= last_row ? 8'd0 : row_q + 8'd1;
        end else begin
          col_q <= col_q + 8'd1;
        end
      end
      mac_valid_q <= enable;
      mac_first_q <= (col_q == 8'd0);
      mac_last_q  <= last_col;
      mac_row_q   <= row_q;
    end
  end

  mac_unit #(
    .DATA_SIZE(DATA_SIZE),
    .FRAC_BITS(FRAC_BITS)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .valid     (mac_valid_q),
    .first     (mac_first_q),
    .last      (mac_last_q),
    .row       (mac_row_q),
    .data_mat  (data_mat),
    .data_vec  (data_vec),
    .row_result(row_result),
    .row_valid (row_valid),
    .row_index (row_index)
  );

endmodule
